// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state enum, default timing and counter width helper for the alarm ringer
// SNOOZE state exists only when ALARM_RINGER_SNOOZE_EN is defined.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1
`ifdef ALARM_RINGER_SNOOZE_EN
      ,
      ST_SNOOZE = 2'd2
`endif
   } ring_state_t;

   localparam int DEF_RING_TIMEOUT_S = 60;
   localparam int DEF_SNOOZE_S       = 300;
   localparam int DEF_MAX_SNOOZE     = 3;
   localparam int DEF_TONE_HALF      = 25000;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// rtl/alarm_tone_gen.sv - buzzer tone divider, toggles TONE every TONE_HALF cycles while EN
// Dropping EN clears both the divider and the tone so each burst starts from the same phase.
module alarm_tone_gen
   import alarm_pkg::*;
#(
   parameter int TONE_HALF = DEF_TONE_HALF
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic EN,
   output logic TONE
);

   localparam int DW = cnt_width(TONE_HALF);
   localparam logic [DW-1:0] DIV_LAST = DW'(TONE_HALF - 1);

   logic [DW-1:0] div_cnt;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         div_cnt <= '0;
         TONE    <= 1'b0;
      end else if (!EN) begin
         div_cnt <= '0;
         TONE    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         TONE    <= ~TONE;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm ringing FSM with timeout, optional snooze and buzzer gating
// Snooze support is compiled in with ALARM_RINGER_SNOOZE_EN.
module alarm_ringer
   import alarm_pkg::*;
#(
   parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
   parameter int SNOOZE_S       = DEF_SNOOZE_S,
   parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE,
   parameter int TONE_HALF      = DEF_TONE_HALF
) (
   input  logic                            CLK,
   input  logic                            RESETN,
   input  logic                            ALARM_DOING,
   input  logic                            SEC_TICK,
   input  logic                            STOP_KEY,
   input  logic                            SNOOZE_KEY,
   output logic                            BUZZER,
   output logic                            RINGING,
   output logic                            SNOOZING,
   output logic [$clog2(MAX_SNOOZE+1)-1:0] SNOOZE_LEFT,
   output logic                            ALARM_ACK
);

   localparam int SLW     = $clog2(MAX_SNOOZE + 1);
   localparam int CNT_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
   localparam int CW      = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] RING_LAST = CW'(RING_TIMEOUT_S - 1);

   ring_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          ack_q, ack_d;
   logic          ringing_q;
   logic          alarm_prev;
   logic          alarm_rise;
   logic          buzz_en;

   assign alarm_rise = ALARM_DOING & ~alarm_prev;
   assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef ALARM_RINGER_SNOOZE_EN
   localparam logic [CW-1:0] SNZ_LAST = CW'(SNOOZE_S - 1);
   logic [SLW-1:0] left_q, left_d;
   logic           snoozing_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
`ifdef ALARM_RINGER_SNOOZE_EN
      left_d  = left_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (alarm_rise) begin
               state_d = ST_RING;
               cnt_d   = '0;
`ifdef ALARM_RINGER_SNOOZE_EN
               left_d  = SLW'(MAX_SNOOZE);
`endif
            end
         end
         ST_RING: begin
            // Stop outranks snooze, which outranks the timeout tick.
            if (STOP_KEY) begin
               state_d = ST_IDLE;
               ack_d   = 1'b1;
            end
`ifdef ALARM_RINGER_SNOOZE_EN
            else if (SNOOZE_KEY && (left_q != '0)) begin
               state_d = ST_SNOOZE;
               left_d  = left_q - 1'b1;
               cnt_d   = '0;
            end
`endif
            else if (SEC_TICK) begin
               if (cnt_q >= RING_LAST) begin
                  state_d = ST_IDLE;
                  ack_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
`ifdef ALARM_RINGER_SNOOZE_EN
         ST_SNOOZE: begin
            if (STOP_KEY) begin
               state_d = ST_IDLE;
               ack_d   = 1'b1;
            end else if (SEC_TICK) begin
               if (cnt_q >= SNZ_LAST) begin
                  state_d = ST_RING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         ringing_q  <= 1'b0;
         alarm_prev <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         ringing_q  <= (state_d == ST_RING);
         alarm_prev <= ALARM_DOING;
      end
   end

`ifdef ALARM_RINGER_SNOOZE_EN
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         left_q     <= '0;
         snoozing_q <= 1'b0;
      end else begin
         left_q     <= left_d;
         snoozing_q <= (state_d == ST_SNOOZE);
      end
   end

   assign SNOOZING    = snoozing_q;
   assign SNOOZE_LEFT = left_q;
`else
   logic unused_snooze_key;
   assign unused_snooze_key = SNOOZE_KEY;
   assign SNOOZING          = 1'b0;
   assign SNOOZE_LEFT       = '0;
`endif

   // Tone sounds in even seconds of RING: 1 s on, 1 s off, starting on.
   assign buzz_en = (state_q == ST_RING) && !cnt_q[0];

   alarm_tone_gen #(
      .TONE_HALF(TONE_HALF)
   ) u_tone (
      .CLK   (CLK),
      .RESETN(RESETN),
      .EN    (buzz_en),
      .TONE  (BUZZER)
   );

   assign RINGING   = ringing_q;
   assign ALARM_ACK = ack_q;

endmodule
